operand_serializer: RTL and testbench
=====================================

# operand_serializer

Upstream feeder for the Moore serial adder: accepts two parallel WIDTH-bit operands through a valid/ready handshake and presents them LSB-first, one bit pair per clock, on the `a`/`b` lines the adder samples. Framing strobes (`bit_valid`, `first_bit`, `last_bit`) let the adder's downstream collector align the serial sum and carry with operand words. Back-to-back words stream with no idle bubble between them.

## Interface
- `WIDTH`, 8, operand width in bits; legal range WIDTH ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair on `a_word`/`b_word` is valid.
- `in_ready`  out  1  block can accept an operand pair this cycle.
- `a_word`  in  WIDTH  operand A, parallel.
- `b_word`  in  WIDTH  operand B, parallel.
- `a`  out  1  serial operand A bit to the adder.
- `b`  out  1  serial operand B bit to the adder.
- `bit_valid`  out  1  `a`/`b` carry a real operand bit this cycle.
- `first_bit`  out  1  current bit is bit 0 (LSB) of a word.
- `last_bit`  out  1  current bit is bit WIDTH-1 (MSB) of a word.

## Operation
- Two states: S_IDLE and S_SHIFT.
- S_IDLE:
  - `in_ready`=1; `a`=`b`=0; all strobes 0.
  - On `in_valid`&&`in_ready`: load `a_word`/`b_word` into shift registers sr_a/sr_b, clear bit counter `cnt`=0, go to S_SHIFT.
- S_SHIFT:
  - `a`=sr_a[0], `b`=sr_b[0], `bit_valid`=1.
  - `first_bit`=(cnt==0); `last_bit`=(cnt==WIDTH-1).
  - While cnt<WIDTH-1: shift sr_a/sr_b right by one (zero fill), cnt+1; `in_ready`=0.
  - At cnt==WIDTH-1: `in_ready`=1.
    - With `in_valid`: reload both registers, cnt=0, stay in S_SHIFT (no bubble).
    - Without `in_valid`: go to S_IDLE.
- Words are never dropped or truncated. `in_valid` without `in_ready` is held by the source and does not disturb the current word.
- `cnt` is $clog2(WIDTH) bits wide. Wrap is explicit reload to 0, never natural overflow, so non-power-of-two WIDTH is legal.
- Reset (`rst`=0, any time, including mid-word):
  - Immediately forces S_IDLE, cnt=0, sr_a=sr_b=0.
  - Outputs: `a`=`b`=`bit_valid`=`first_bit`=`last_bit`=0; `in_ready`=1 (S_IDLE decode).
  - A partially shifted word is discarded.

## Timing
- Operand accepted at edge k. Bit i appears during cycle k+1+i, for i = 0..WIDTH-1.
- Latency from accept to LSB: 1 cycle. Throughput: one word per WIDTH cycles sustained.
- `a`, `b` and the strobes come from registered state only. No combinational path from `in_valid`/`a_word`/`b_word` to any output.
- `in_ready` decodes state and `cnt` only; it does not depend on `in_valid`.
- Deassertion of `rst` is synchronized externally. The first accept is possible on the first rising edge after release.

## Structure
- Shared package `serial_pkg`:
  - State typedef (S_IDLE, S_SHIFT).
  - Default WIDTH constant, shared with the serial adder and sum collector.
- One sub-module: `piso_reg` (WIDTH-bit parallel-load, right-shift register with load/shift enables), instantiated once each for A and B.
- FSM and counter live in the top module.

## Test plan
- Reset mid-word: WIDTH=4, accept A=4'b1011, assert `rst` low after 2 bits -> outputs 0 and `in_ready`=1 at once. After release, a fresh word serializes from bit 0.
- Single word: WIDTH=4, A=4'b1011, B=4'b0110 -> `a` sequence 1,1,0,1; `b` sequence 0,1,1,0.
  - `first_bit` on cycle 1, `last_bit` on cycle 4, then S_IDLE.
  - The downstream adder yields sum 0001 with carry 1 (11+6=17).
- Back-to-back: words (4'hF,4'h1) then (4'h3,4'h5), `in_valid` held high -> 8 consecutive `bit_valid` cycles with no gap; `first_bit` on cycles 1 and 5.
- Backpressure: `in_valid` high mid-word with a new value -> `in_ready`=0 until the last bit. The new word is accepted only at that edge, and the current word's bits are unchanged.
- Idle gap: one word, then `in_valid` low for 3 cycles -> `bit_valid`=0 and `a`=`b`=0 for exactly those cycles.
- Odd width: WIDTH=5, A=5'b10011 -> `a` sequence 1,1,0,0,1; `last_bit` on the 5th bit; counter reloads cleanly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial adder datapath: the operand serializer,
// the Moore serial adder and the sum collector all agree on these.
package serial_pkg;

  // Default operand width, shared by all blocks of the serial adder chain.
  localparam int SERIAL_WIDTH = 8;

  // Serializer control states.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/piso_reg.sv
// Parallel-in / serial-out register. Loads a WIDTH-bit word in parallel and
// shifts it right (zero fill) so the word leaves LSB first on lsb_o.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, clears the register
//   load_i  : load din_i this cycle (has priority over shift_i)
//   shift_i : shift right by one this cycle
//   din_i   : parallel word
//   lsb_o   : current bit 0 of the register
module piso_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign lsb_o = sr_q[0];

endmodule

// File: rtl/operand_serializer.sv
// Operand serializer: accepts two parallel WIDTH-bit operands over a
// valid/ready handshake and streams them LSB first, one bit pair per clock,
// to the Moore serial adder. Consecutive words stream without a bubble.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : operand pair on a_word/b_word is valid
//   in_ready  : block accepts an operand pair this cycle
//   a_word    : operand A, parallel
//   b_word    : operand B, parallel
//   a, b      : serial operand bits to the adder
//   bit_valid : a/b carry a real operand bit
//   first_bit : current bit is the LSB of a word
//   last_bit  : current bit is the MSB of a word
module operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             a,
  output logic             b,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift;
  logic             at_last;
  logic             shifting;
  logic             sr_a_lsb, sr_b_lsb;

  assign shifting = (state_q == S_SHIFT);
  assign at_last  = shifting && (cnt_q == CNT_LAST);

  // Ready depends only on registered state so the source sees no loop
  // through in_valid; the last bit slot doubles as the accept slot.
  assign in_ready = !shifting || at_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (in_valid && in_ready) begin
      load    = 1'b1;
      cnt_d   = '0;
      state_d = S_SHIFT;
    end else if (at_last) begin
      cnt_d   = '0;
      state_d = S_IDLE;
    end else if (shifting) begin
      shift   = 1'b1;
      // Explicit reload above keeps non-power-of-two widths correct.
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (a_word),
    .lsb_o   (sr_a_lsb)
  );

  piso_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (b_word),
    .lsb_o   (sr_b_lsb)
  );

  // Outputs are gated by state so the lines idle at zero between words.
  assign a         = shifting && sr_a_lsb;
  assign b         = shifting && sr_b_lsb;
  assign bit_valid = shifting;
  assign first_bit = shifting && (cnt_q == '0);
  assign last_bit  = at_last;

endmodule

// File: tb/tb_operand_serializer.sv
module tb_operand_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       rst4 = 1'b0, v4 = 1'b0;
  logic [3:0] aw4 = '0, bw4 = '0;
  logic       rdy4, a4, b4, bv4, fb4, lb4;

  // WIDTH=5 instance
  logic       rst5 = 1'b0, v5 = 1'b0;
  logic [4:0] aw5 = '0, bw5 = '0;
  logic       rdy5, a5, b5, bv5, fb5, lb5;

  operand_serializer #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst4), .in_valid(v4), .in_ready(rdy4),
    .a_word(aw4), .b_word(bw4), .a(a4), .b(b4),
    .bit_valid(bv4), .first_bit(fb4), .last_bit(lb4)
  );

  operand_serializer #(.WIDTH(5)) u_w5 (
    .clk(clk), .rst(rst5), .in_valid(v5), .in_ready(rdy5),
    .a_word(aw5), .b_word(bw5), .a(a5), .b(b5),
    .bit_valid(bv5), .first_bit(fb5), .last_bit(lb5)
  );

  // Per-cycle record: inputs driven after the falling edge, expected outputs
  // {a, b, bit_valid, first_bit, last_bit, in_ready} sampled 1 time unit later.
  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] aw;
    logic [3:0] bw;
    logic [5:0] exp;
  } vec_t;

  localparam int N4 = 29;
  vec_t tab[N4];

  int total = 0;
  int bad   = 0;

  logic [5:0] got, exp5;
  logic [4:0] wa[2], wb[2];

  initial begin
    // reset state
    tab[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 6'b000001};
    // single word A=1011 B=0110, accepted at the edge after this cycle
    tab[1]  = '{1'b1, 1'b1, 4'hB, 4'h6, 6'b000001};
    tab[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b101100};
    tab[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b111000};
    tab[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b011000};
    tab[5]  = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b101011};
    // idle gap of three cycles
    tab[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b000001};
    tab[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b000001};
    tab[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b000001};
    // back-to-back (F,1) then (3,5) with valid held high (backpressure)
    tab[9]  = '{1'b1, 1'b1, 4'hF, 4'h1, 6'b000001};
    tab[10] = '{1'b1, 1'b1, 4'h3, 4'h5, 6'b111100};
    tab[11] = '{1'b1, 1'b1, 4'h3, 4'h5, 6'b101000};
    tab[12] = '{1'b1, 1'b1, 4'h3, 4'h5, 6'b101000};
    tab[13] = '{1'b1, 1'b1, 4'h3, 4'h5, 6'b101011};
    tab[14] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b111100};
    tab[15] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b101000};
    tab[16] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b011000};
    tab[17] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b001011};
    tab[18] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b000001};
    // reset mid-word: A=1011, reset after two bits, checked before any edge
    tab[19] = '{1'b1, 1'b1, 4'hB, 4'h6, 6'b000001};
    tab[20] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b101100};
    tab[21] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b111000};
    tab[22] = '{1'b0, 1'b0, 4'h0, 4'h0, 6'b000001};
    // fresh word A=1101 B=1001 after release
    tab[23] = '{1'b1, 1'b1, 4'hD, 4'h9, 6'b000001};
    tab[24] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b111100};
    tab[25] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b001000};
    tab[26] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b101000};
    tab[27] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b111011};
    tab[28] = '{1'b1, 1'b0, 4'h0, 4'h0, 6'b000001};

    for (int i = 0; i < N4; i++) begin
      @(negedge clk);
      rst4 = tab[i].rst;
      v4   = tab[i].vld;
      aw4  = tab[i].aw;
      bw4  = tab[i].bw;
      #1;
      got = {a4, b4, bv4, fb4, lb4, rdy4};
      total++;
      if (got !== tab[i].exp) begin
        bad++;
        $display("FAIL w4_step%0d got=%b want=%b (a b bv first last rdy)",
                 i, got, tab[i].exp);
      end
    end

    // WIDTH=5: two words, second held under backpressure then reloaded
    wa[0] = 5'b10011; wb[0] = 5'b01101;
    wa[1] = 5'b00110; wb[1] = 5'b11111;

    @(negedge clk);
    total++;
    if ({a5, b5, bv5, fb5, lb5, rdy5} !== 6'b000001) begin
      bad++;
      $display("FAIL w5_reset got=%b want=000001", {a5, b5, bv5, fb5, lb5, rdy5});
    end
    rst5 = 1'b1;
    v5   = 1'b1;
    aw5  = wa[0];
    bw5  = wb[0];

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (w == 0) begin
          v5  = 1'b1;
          aw5 = wa[1];
          bw5 = wb[1];
        end else begin
          v5  = 1'b0;
          aw5 = '0;
          bw5 = '0;
        end
        #1;
        exp5 = {wa[w][i], wb[w][i], 1'b1, (i == 0), (i == 4), (i == 4)};
        got  = {a5, b5, bv5, fb5, lb5, rdy5};
        total++;
        if (got !== exp5) begin
          bad++;
          $display("FAIL w5_word%0d_bit%0d got=%b want=%b", w, i, got, exp5);
        end
      end
    end

    @(negedge clk);
    #1;
    total++;
    if ({a5, b5, bv5, fb5, lb5, rdy5} !== 6'b000001) begin
      bad++;
      $display("FAIL w5_idle got=%b want=000001", {a5, b5, bv5, fb5, lb5, rdy5});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
